// File: rtl/genius_round_if.sv
// genius_round_if
// Groups the signals between the Genius round controller and the rest of the
// game: player inputs, the sequence-memory read port and the status outputs
// used by the display and LED logic.
//
// Signals:
//   start      - level signal, a rising edge starts a game
//   btn[2:0]   - debounced player buttons, bit i = symbol i
//   seq_data   - sequence symbol at seq_addr (combinational read)
//   seq_addr   - sequence index being shown or checked
//   show_valid - high while a symbol is displayed
//   show_value - displayed symbol, 0 when nothing is shown
//   level      - current level, round length is level+1
//   progress   - correct presses accepted in the current round
//   state_code - IDLE=0 SHOW_ON=1 SHOW_GAP=2 WAIT_INPUT=3 LEVEL_UP=4 WIN=5 FAIL=6
//   game_over  - high in WIN or FAIL
//   won        - high in WIN only
//
// Modports:
//   master - the round controller
//   slave  - the surrounding game logic
interface genius_round_if;
  logic       start;
  logic [2:0] btn;
  logic [1:0] seq_data;
  logic [3:0] seq_addr;
  logic       show_valid;
  logic [1:0] show_value;
  logic [3:0] level;
  logic [3:0] progress;
  logic [2:0] state_code;
  logic       game_over;
  logic       won;

  modport master (
    input  start, btn, seq_data,
    output seq_addr, show_valid, show_value, level, progress,
           state_code, game_over, won
  );

  modport slave (
    output start, btn, seq_data,
    input  seq_addr, show_valid, show_value, level, progress,
           state_code, game_over, won
  );
endinterface

// File: rtl/genius_round_controller.sv
// genius_round_controller
// Timed game-flow controller for the Genius datapath. It replays the current
// level from the sequence memory (each symbol shown for SHOW_TICKS ticks,
// followed by GAP_TICKS ticks of blank), then checks the player's button
// presses against the sequence with a per-press timeout, and reports
// level/progress/win/fail status.
//
// Ports:
//   clock - system clock
//   reset - synchronous, active-low
//   bus   - genius_round_if master modport (start, btn, seq_data in;
//           seq_addr, show_valid, show_value, level, progress, state_code,
//           game_over, won out)
//
// Parameters:
//   TICK_DIV      - clock cycles per game tick (>= 2)
//   SHOW_TICKS    - ticks each symbol is shown
//   GAP_TICKS     - ticks of blank between symbols
//   TIMEOUT_TICKS - ticks allowed per player press
//   MAX_LEVEL     - final level index (<= 15)
module genius_round_controller #(
  parameter int TICK_DIV      = 25000000,
  parameter int SHOW_TICKS    = 2,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 10,
  parameter int MAX_LEVEL     = 15
) (
  input  logic          clock,
  input  logic          reset,
  genius_round_if.master bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHOW_ON    = 3'd1,
    SHOW_GAP   = 3'd2,
    WAIT_INPUT = 3'd3,
    LEVEL_UP   = 3'd4,
    WIN        = 3'd5,
    FAIL       = 3'd6
  } state_t;

  localparam int TICK_MAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TICK_MAX   = (TICK_MAX_A > TIMEOUT_TICKS) ? TICK_MAX_A : TIMEOUT_TICKS;
  localparam int TW         = $clog2(TICK_MAX + 1);
  localparam int PW         = $clog2(TICK_DIV);

  localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]    MAX_LVL      = 4'(MAX_LEVEL);

  state_t        state_q, state_d;
  logic [3:0]    level_q, level_d;
  logic [3:0]    seq_addr_q, seq_addr_d;
  logic [3:0]    progress_q, progress_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          start_q, start_d;
  logic [2:0]    btn_q, btn_d;
  logic          start_armed_q, start_armed_d;

  logic          start_edge;
  logic [2:0]    press;
  logic          tick;
  logic [2:0]    expected_press;
  logic          restart_timer;
  logic          timed_state;

  // start_q loads 0 in reset, so a start held high through reset release
  // would look like a rising edge. start_armed_q only sets once start has
  // been seen low after reset, which suppresses that false edge.
  always_comb begin
    start_d       = bus.start;
    btn_d         = bus.btn;
    start_armed_d = start_armed_q | ~bus.start;
    start_edge    = bus.start & ~start_q & start_armed_q;
    press         = bus.btn & ~btn_q;
    tick          = (presc_q == PRESC_LAST);
    timed_state   = (state_q == SHOW_ON) || (state_q == SHOW_GAP) ||
                    (state_q == WAIT_INPUT);
  end

  // One-hot button pattern that matches the current symbol. Symbol 3 has no
  // button, so any press against it is wrong.
  always_comb begin
    expected_press = 3'b000;
    case (bus.seq_data)
      2'd0:    expected_press = 3'b001;
      2'd1:    expected_press = 3'b010;
      2'd2:    expected_press = 3'b100;
      default: expected_press = 3'b000;
    endcase
  end

  // Next-state and datapath update for the game flow.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    seq_addr_d    = seq_addr_q;
    progress_d    = progress_q;
    restart_timer = 1'b0;

    case (state_q)
      IDLE, WIN, FAIL: begin
        if (start_edge) begin
          level_d    = 4'd0;
          seq_addr_d = 4'd0;
          progress_d = 4'd0;
          state_d    = SHOW_ON;
        end
      end

      SHOW_ON: begin
        if (tick && (tick_cnt_q == SHOW_LAST)) begin
          state_d = SHOW_GAP;
        end
      end

      SHOW_GAP: begin
        if (tick && (tick_cnt_q == GAP_LAST)) begin
          if (seq_addr_q == level_q) begin
            seq_addr_d = 4'd0;
            progress_d = 4'd0;
            state_d    = WAIT_INPUT;
          end else begin
            seq_addr_d = seq_addr_q + 4'd1;
            state_d    = SHOW_ON;
          end
        end
      end

      // A press always wins over a timeout landing in the same cycle.
      WAIT_INPUT: begin
        if (press != 3'b000) begin
          if ((expected_press != 3'b000) && (press == expected_press)) begin
            progress_d = progress_q + 4'd1;
            if (seq_addr_q == level_q) begin
              state_d = LEVEL_UP;
            end else begin
              seq_addr_d    = seq_addr_q + 4'd1;
              restart_timer = 1'b1;
            end
          end else begin
            state_d = FAIL;
          end
        end else if (tick && (tick_cnt_q == TIMEOUT_LAST)) begin
          state_d = FAIL;
        end
      end

      LEVEL_UP: begin
        if (level_q == MAX_LVL) begin
          state_d = WIN;
        end else begin
          level_d    = level_q + 4'd1;
          seq_addr_d = 4'd0;
          progress_d = 4'd0;
          state_d    = SHOW_ON;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Prescaler and tick counter restart on every state change (and on each
  // accepted press) so a state lasting N ticks holds exactly N*TICK_DIV
  // cycles. The tick counter only advances in the timed states, so it never
  // runs past the longest interval.
  always_comb begin
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    if ((state_d != state_q) || restart_timer) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end else begin
      presc_d = tick ? '0 : (presc_q + PW'(1));
      if (tick && timed_state) begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      level_q       <= 4'd0;
      seq_addr_q    <= 4'd0;
      progress_q    <= 4'd0;
      presc_q       <= '0;
      tick_cnt_q    <= '0;
      start_q       <= 1'b0;
      btn_q         <= 3'b000;
      start_armed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      seq_addr_q    <= seq_addr_d;
      progress_q    <= progress_d;
      presc_q       <= presc_d;
      tick_cnt_q    <= tick_cnt_d;
      start_q       <= start_d;
      btn_q         <= btn_d;
      start_armed_q <= start_armed_d;
    end
  end

  always_comb begin
    bus.seq_addr   = seq_addr_q;
    bus.level      = level_q;
    bus.progress   = progress_q;
    bus.state_code = state_q;
    bus.show_valid = (state_q == SHOW_ON);
    bus.show_value = (state_q == SHOW_ON) ? bus.seq_data : 2'd0;
    bus.game_over  = (state_q == WIN) || (state_q == FAIL);
    bus.won        = (state_q == WIN);
  end

endmodule
